// File: rtl/mem_hex_formatter.sv
// mem_hex_formatter
//
// Turns one {address, 32-bit data} record into a printable ASCII hex line
// such as "00012: DEADBEEF\r\n" for the serial dump path. It sits between
// the memory dump sequencer (record side) and the UART transmitter (byte
// side).
//
// Build option:
//   FMT_ADDR_EN  defined   -> line is address digits, ": ", 8 data digits, CRLF
//                undefined -> line is 8 data digits, CRLF; in_addr is ignored
//
// Parameters:
//   ADDR_W       width of in_addr
//   ADDR_DIGITS  hex digits printed for the address (zero-extend / truncate)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     record available
//   in_ready     formatter idle and able to accept a record
//   in_addr      word address of the record
//   in_data      data word of the record
//   uart_valid   uart_data holds a byte to send (registered)
//   uart_ready   transmitter accepts the byte
//   uart_data    ASCII byte (registered)
//   busy         a line is in progress

module mem_hex_formatter #(
  parameter int ADDR_W      = 17,
  parameter int ADDR_DIGITS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  output logic              uart_valid,
  input  logic              uart_ready,
  output logic [7:0]        uart_data,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef FMT_ADDR_EN
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COLON = 3'd2;
  localparam logic [2:0] S_SPACE = 3'd3;
`endif
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CR    = 3'd5;
  localparam logic [2:0] S_LF    = 3'd6;

  // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37).
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  dig_q, dig_d;
  logic [31:0] data_q, data_d;
  logic        uart_valid_q, uart_valid_d;
  logic [7:0]  uart_data_q, uart_data_d;
  logic        accept;
  logic        xfer;

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign uart_valid = uart_valid_q;
  assign uart_data  = uart_data_q;
  assign accept     = in_valid && in_ready;
  assign xfer       = uart_valid_q && uart_ready;

`ifdef FMT_ADDR_EN
  localparam int AW4 = 4 * ADDR_DIGITS;

  logic [AW4-1:0] addr_q, addr_d;
  logic [AW4-1:0] addr_ext;

  // Fit the incoming address to exactly ADDR_DIGITS nibbles.
  generate
    if (ADDR_W >= AW4) begin : g_addr_trunc
      assign addr_ext = in_addr[AW4-1:0];
    end else begin : g_addr_zext
      assign addr_ext = {{(AW4-ADDR_W){1'b0}}, in_addr};
    end
  endgenerate
`else
  // Address path compiled out: keep the port, consume it harmlessly.
  localparam int unused_addr_digits = ADDR_DIGITS;
  logic unused_addr;
  assign unused_addr = ^in_addr;
`endif

  // The captured address/data registers are shifted left one nibble per
  // emitted digit, so the next digit to print is always the top nibble.
  // The digit counter only decides when a field is finished.
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    dig_d        = dig_q;
    data_d       = data_q;
    uart_valid_d = uart_valid_q;
    uart_data_d  = uart_data_q;
`ifdef FMT_ADDR_EN
    addr_d       = addr_q;
`endif

    if (accept) begin
      data_d       = in_data;
      dig_d        = 4'd0;
      uart_valid_d = 1'b1;
`ifdef FMT_ADDR_EN
      addr_d       = addr_ext;
      state_d      = S_ADDR;
      uart_data_d  = hex_ascii(addr_ext[AW4-1 -: 4]);
`else
      state_d      = S_DATA;
      uart_data_d  = hex_ascii(in_data[31:28]);
`endif
    end else if (xfer) begin
      // Load the byte that follows the one just transferred; uart_data only
      // changes here, so it is held while the transmitter stalls.
      case (state_q)
`ifdef FMT_ADDR_EN
        S_ADDR: begin
          if (dig_q == 4'(ADDR_DIGITS - 1)) begin
            state_d     = S_COLON;
            uart_data_d = 8'h3A;
          end else begin
            dig_d       = dig_q + 4'd1;
            addr_d      = addr_q << 4;
            uart_data_d = hex_ascii(addr_d[AW4-1 -: 4]);
          end
        end
        S_COLON: begin
          state_d     = S_SPACE;
          uart_data_d = 8'h20;
        end
        S_SPACE: begin
          state_d     = S_DATA;
          dig_d       = 4'd0;
          uart_data_d = hex_ascii(data_q[31:28]);
        end
`endif
        S_DATA: begin
          if (dig_q == 4'd7) begin
            state_d     = S_CR;
            uart_data_d = 8'h0D;
          end else begin
            dig_d       = dig_q + 4'd1;
            data_d      = data_q << 4;
            uart_data_d = hex_ascii(data_d[31:28]);
          end
        end
        S_CR: begin
          state_d     = S_LF;
          uart_data_d = 8'h0A;
        end
        S_LF: begin
          state_d      = S_IDLE;
          dig_d        = 4'd0;
          uart_valid_d = 1'b0;
        end
        default: begin
          state_d      = S_IDLE;
          uart_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dig_q        <= 4'd0;
      data_q       <= 32'h0;
      uart_valid_q <= 1'b0;
      uart_data_q  <= 8'h00;
`ifdef FMT_ADDR_EN
      addr_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      dig_q        <= dig_d;
      data_q       <= data_d;
      uart_valid_q <= uart_valid_d;
      uart_data_q  <= uart_data_d;
`ifdef FMT_ADDR_EN
      addr_q       <= addr_d;
`endif
    end
  end

endmodule
